// File: rtl/alu_arbiter_if.sv
// Request/result bundle between the issuing requesters and the shared ALU arbiter.
// slave: arbiter side (takes req_*, res_ready; drives grants, result, stall count).
interface alu_arbiter_if #(
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*4-1:0]  req_op;
    logic               res_valid;
    logic               res_ready;
    logic [31:0]        res_data;
    logic [IDW-1:0]     res_id;
    logic               res_err;
    logic [15:0]        stall_cnt;

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err, stall_cnt
    );

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err, stall_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one 32-bit ALU among NREQ requesters, registered tagged result.
// Ports: clk, rst (sync, active high), bus (alu_arbiter_if.slave: requests and result).
module alu_arbiter #(
    parameter int NREQ = 2
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gnt_idx;
    logic           found;
    logic           can_take;
    logic           gnt;
    logic [NREQ-1:0] ready;

    logic [31:0]    op_a, op_b;
    logic [3:0]     op;
    logic [31:0]    alu_res;
    logic           alu_ill;

    logic           res_valid_q;
    logic [31:0]    res_data_q;
    logic [IDW-1:0] res_id_q;
    logic           res_err_q;
    logic [15:0]    stall_q;

    assign can_take = !res_valid_q || bus.res_ready;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
    end

    assign gnt = found && can_take && !rst;

    always_comb begin
        ready = '0;
        if (gnt) ready[gnt_idx] = 1'b1;
    end

    assign op_a = bus.req_a[32*gnt_idx +: 32];
    assign op_b = bus.req_b[32*gnt_idx +: 32];
    assign op   = bus.req_op[4*gnt_idx +: 4];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            4'b0000: alu_res = op_a + op_b;
            4'b1000: alu_res = op_a - op_b;
            4'b0010: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_res = {31'd0, op_a < op_b};
            4'b0001: alu_res = op_a << op_b[4:0];
            4'b0101: alu_res = op_a >> op_b[4:0];
            4'b1101: alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            4'b0100: alu_res = op_a ^ op_b;
            4'b0110: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            default: alu_ill = 1'b1;
        endcase
    end

    assign ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            if (gnt) begin
                ptr_q       <= ptr_d;
                res_valid_q <= 1'b1;
                res_data_q  <= alu_res;
                res_id_q    <= gnt_idx;
                res_err_q   <= alu_ill;
            end else if (bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (|bus.req_valid && !can_take && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = res_err_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, corner sequences, random vs model.
// Drives inputs and samples outputs at the falling edge.
module tb_alu_arbiter;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();
    alu_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    int          m_ptr = 0;
    bit          m_valid = 0;
    logic [31:0] m_data = 0;
    int          m_id = 0;
    bit          m_err = 0;
    int          m_stall = 0;
    int          last_g = -1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t tab[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op,
                                    output logic [31:0] r, output logic e);
        longint unsigned sh;
        logic [63:0] ext;
        sh = longint'(b[4:0]);
        e = 0;
        r = 0;
        case (op)
            4'h0: r = 32'(longint'(a) + longint'(b));
            4'h8: r = 32'(longint'(a) + 64'h1_0000_0000 - longint'(b));
            4'h2: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 1 : 0;
            4'h3: r = (a < b) ? 1 : 0;
            4'h1: r = 32'(longint'(a) * (64'd1 << sh));
            4'h5: r = 32'(longint'(a) / (64'd1 << sh));
            4'hD: begin
                ext = {{32{a[31]}}, a};
                r = 32'(ext / (64'd1 << sh));
            end
            4'h4: r = a ^ b;
            4'h6: r = a | b;
            4'h7: r = a & b;
            default: e = 1;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic [NREQ-1:0] v,
                         input logic [NREQ*32-1:0] a, input logic [NREQ*32-1:0] b,
                         input logic [NREQ*4-1:0] op, input logic rr);
        bit can;
        int g;
        int idx;
        logic [31:0] res;
        logic e;
        @(negedge clk);
        chk("res_valid", bus.res_valid, m_valid);
        if (m_valid) begin
            chk("res_data", bus.res_data, m_data);
            chk("res_id", bus.res_id, m_id);
            chk("res_err", bus.res_err, m_err);
        end
        chk("stall_cnt", bus.stall_cnt, m_stall);
        rst = r;
        bus.req_valid = v;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_op = op;
        bus.res_ready = rr;
        #1;
        can = !m_valid || rr;
        g = -1;
        if (!r && can)
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (v[idx] && g < 0) g = idx;
            end
        chk("req_ready", bus.req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        last_g = g;
        if (r) begin
            m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_stall = 0;
        end else begin
            if (|v && !can && m_stall < 65535) m_stall++;
            if (g >= 0) begin
                ref_alu(a[32*g +: 32], b[32*g +: 32], op[4*g +: 4], res, e);
                m_valid = 1; m_data = res; m_id = g; m_err = e;
                m_ptr = (g + 1) % NREQ;
            end else if (rr) begin
                m_valid = 0;
            end
        end
    endtask

    logic [NREQ-1:0]    rv;
    logic [NREQ*32-1:0] ra, rb;
    logic [NREQ*4-1:0]  rop;
    int prev_g;
    logic [31:0] held;
    int s0;

    initial begin
        tab[0]  = '{32'h8000_0000, 32'd1, 4'hD, 32'hC000_0000, 1'b0};
        tab[1]  = '{32'h8000_0000, 32'd1, 4'h5, 32'h4000_0000, 1'b0};
        tab[2]  = '{32'h8000_0000, 32'd1, 4'h2, 32'd1, 1'b0};
        tab[3]  = '{32'h8000_0000, 32'd1, 4'h3, 32'd0, 1'b0};
        tab[4]  = '{32'd0, 32'd1, 4'h8, 32'hFFFF_FFFF, 1'b0};
        tab[5]  = '{32'd5, 32'd3, 4'hF, 32'd0, 1'b1};
        tab[6]  = '{32'd5, 32'd3, 4'h0, 32'd8, 1'b0};
        tab[7]  = '{32'hF0, 32'h0F, 4'h6, 32'hFF, 1'b0};
        tab[8]  = '{32'hF0, 32'hFF, 4'h7, 32'hF0, 1'b0};
        tab[9]  = '{32'hF0, 32'hFF, 4'h4, 32'h0F, 1'b0};
        tab[10] = '{32'd1, 32'd36, 4'h1, 32'h10, 1'b0};

        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_op = '0; bus.res_ready = 1'b0;

        // single op after 2 reset cycles
        cycle(1, '0, '0, '0, '0, 0);
        cycle(1, '0, '0, '0, '0, 0);
        cycle(0, 2'b01, {32'd0, 32'd5}, {32'd0, 32'd3}, 8'h00, 1);
        @(posedge clk); #1;
        chk("t1 valid", bus.res_valid, 1);
        chk("t1 data", bus.res_data, 32'd8);
        chk("t1 id", bus.res_id, 0);
        chk("t1 err", bus.res_err, 0);

        // op table on requester 0
        foreach (tab[i]) begin
            cycle(0, 2'b01, {32'd0, tab[i].a}, {32'd0, tab[i].b}, {4'h0, tab[i].op}, 1);
            @(posedge clk); #1;
            chk($sformatf("tab%0d data", i), bus.res_data, tab[i].exp);
            chk($sformatf("tab%0d err", i), bus.res_err, tab[i].err);
        end

        // round-robin alternation
        prev_g = -1;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 2'b11, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 1);
            if (prev_g >= 0) chk("rr alternate", last_g, prev_g ^ 1);
            prev_g = last_g;
        end

        // backpressure: hold result, count stalls, then retire+grant together
        cycle(0, 2'b11, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 0);
        held = m_data;
        s0 = m_stall;
        for (int i = 0; i < 3; i++)
            cycle(0, 2'b11, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 0);
        @(posedge clk); #1;
        chk("bp data stable", bus.res_data, held);
        chk("bp stall", bus.stall_cnt, 32'(s0 + 3));
        cycle(0, 2'b11, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 1);
        chk("bp regrant", last_g >= 0, 1);

        // reset mid-stream
        cycle(0, 2'b01, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 0);
        cycle(1, 2'b11, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 0);
        cycle(0, 2'b11, {32'd7, 32'd1}, {32'd2, 32'd2}, 8'h00, 1);
        chk("post-reset grant", last_g, 0);

        // random traffic, requesters hold until accepted
        rv = '0; ra = '0; rb = '0; rop = '0;
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!rv[i] && $urandom_range(0, 1) == 1) begin
                    rv[i] = 1'b1;
                    ra[32*i +: 32] = $urandom;
                    rb[32*i +: 32] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
                    rop[4*i +: 4] = 4'($urandom_range(0, 15));
                end
            cycle(0, rv, ra, rb, rop, $urandom_range(0, 3) != 0);
            if (last_g >= 0) rv[last_g] = 1'b0;
        end
        cycle(0, '0, '0, '0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
